// File: rtl/id_stage_ras_pkg.sv
// Shared definitions for the id_stage_ras decode stage.
// Contents:
//   - opcode encodings OP_NOP..OP_ILL;
//   - branch condition codes selected by ra[1:0];
//   - helpers giving instruction width and field offsets as functions of W and RA_W.
// Instruction layout (MSB to LSB): imm[W] | opcode[4] | ra[RA_W] | rb[RA_W].
package id_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_SHL  = 4'h5;
    localparam logic [3:0] OP_SHR  = 4'h6;
    localparam logic [3:0] OP_LDI  = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_IN   = 4'hA;
    localparam logic [3:0] OP_OUT  = 4'hB;
    localparam logic [3:0] OP_BR   = 4'hC;
    localparam logic [3:0] OP_CALL = 4'hD;
    localparam logic [3:0] OP_RET  = 4'hE;
    localparam logic [3:0] OP_ILL  = 4'hF;

    localparam logic [1:0] COND_AL = 2'b00;
    localparam logic [1:0] COND_Z  = 2'b01;
    localparam logic [1:0] COND_N  = 2'b10;
    localparam logic [1:0] COND_NZ = 2'b11;

    function automatic int instr_w(input int w, input int ra_w);
        return w + 4 + 2 * ra_w;
    endfunction

    function automatic int imm_lsb(input int ra_w);
        return 4 + 2 * ra_w;
    endfunction

    function automatic int op_lsb(input int ra_w);
        return 2 * ra_w;
    endfunction

    function automatic int ra_lsb(input int ra_w);
        return ra_w;
    endfunction

endpackage

// File: rtl/id_stage_ras_if.sv
// Bundle of all decode-stage signals except clock and reset.
// Modports:
//   - master: drives Instruction/PC_in/write-back/hazard/flags and observes the decoded outputs;
//   - slave:  the decode stage itself.
interface id_stage_ras_if #(
    parameter int W         = 8,
    parameter int NREGS     = 4,
    parameter int RAS_DEPTH = 4
);
    import id_pkg::*;

    localparam int RA_W = $clog2(NREGS);
    localparam int IW   = instr_w(W, RA_W);
    localparam int CW   = $clog2(RAS_DEPTH) + 1;

    logic [IW-1:0]   Instruction;
    logic [W-1:0]    PC_in;
    logic [W-1:0]    Result_WB;
    logic            writeBackEn;
    logic [RA_W-1:0] Dest_wb;
    logic            hazard;
    logic            Z;
    logic            N;

    logic            WB_EN;
    logic            MEM_R_EN;
    logic            MEM_W_EN;
    logic            S;
    logic            inPort;
    logic            outPort;
    logic [3:0]      EXE_CMD;
    logic [W-1:0]    Val_Ra;
    logic [W-1:0]    Val_Rb;
    logic            imm;
    logic [W-1:0]    Val_Imm;
    logic [RA_W-1:0] Dest;
    logic [RA_W-1:0] src1;
    logic [RA_W-1:0] src2;
    logic            src1_en;
    logic            src2_en;
    logic [W-1:0]    Br_addr;
    logic            B;
    logic            illegal;
    logic [CW-1:0]   ras_count;
    logic            ras_ovf;
    logic            ras_unf;

    modport master (
        output Instruction, PC_in, Result_WB, writeBackEn, Dest_wb, hazard, Z, N,
        input  WB_EN, MEM_R_EN, MEM_W_EN, S, inPort, outPort, EXE_CMD, Val_Ra, Val_Rb,
               imm, Val_Imm, Dest, src1, src2, src1_en, src2_en, Br_addr, B, illegal,
               ras_count, ras_ovf, ras_unf
    );

    modport slave (
        input  Instruction, PC_in, Result_WB, writeBackEn, Dest_wb, hazard, Z, N,
        output WB_EN, MEM_R_EN, MEM_W_EN, S, inPort, outPort, EXE_CMD, Val_Ra, Val_Rb,
               imm, Val_Imm, Dest, src1, src2, src1_en, src2_en, Br_addr, B, illegal,
               ras_count, ras_ovf, ras_unf
    );

endinterface

// File: rtl/id_stage_ras_ras_stack.sv
// Return-address stack: circular buffer of DEPTH entries plus a valid count.
// Ports:
//   - clk, rst_n: clock and asynchronous active-low reset;
//   - push/din:   store din as the new top (overwrites the oldest entry when full);
//   - pop:        discard the top entry;
//   - top:        current top entry, 0 when empty;
//   - count:      number of valid entries;
//   - ovf, unf:   sticky overflow / underflow flags.
module ras_stack #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               top,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf,
    output logic                       unf
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // ptr_q is the next free slot; the top entry sits one below it.
    logic [PW-1:0] ptr_q, ptr_d, ptr_inc, ptr_dec;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d, unf_q, unf_d;
    logic [W-1:0]  mem_q [DEPTH];

    // A one-entry stack keeps its pointer pinned at slot 0.
    function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p);
        return (DEPTH == 1) ? '0 : p;
    endfunction

    assign ptr_inc = wrap(ptr_q + 1'b1);
    assign ptr_dec = wrap(ptr_q - 1'b1);

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (push) begin
            ptr_d = ptr_inc;
            if (cnt_q == FULL) ovf_d = 1'b1;
            else               cnt_d = cnt_q + 1'b1;
        end else if (pop) begin
            if (cnt_q == '0) begin
                unf_d = 1'b1;
            end else begin
                ptr_d = ptr_dec;
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Entry storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[ptr_q] <= din;
    end

    assign top   = (cnt_q == '0) ? '0 : mem_q[ptr_dec];
    assign count = cnt_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule

// File: rtl/id_stage_ras.sv
// Decode stage: instruction decode, register file with write-back bypass,
// branch/CALL/RET resolution and a return-address stack.
// Ports:
//   - clk, rst: clock and asynchronous active-low reset;
//   - bus:      id_stage_ras_if slave (instruction, PC_in, write-back, hazard, flags in;
//               EX controls, operands, branch result and RAS status out).
// All outputs are combinational; RF and RAS updates appear the cycle after.
module id_stage_ras
    import id_pkg::*;
#(
    parameter int W         = 8,
    parameter int NREGS     = 4,
    parameter int RAS_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    id_stage_ras_if.slave  bus
);
    localparam int RA_W = $clog2(NREGS);
    localparam int IMM_L = imm_lsb(RA_W);
    localparam int OP_L  = op_lsb(RA_W);
    localparam int RA_L  = ra_lsb(RA_W);

    logic [3:0]      opcode;
    logic [RA_W-1:0] ra, rb;
    logic [W-1:0]    imm_f;
    logic [1:0]      cond;

    assign opcode = bus.Instruction[OP_L +: 4];
    assign ra     = bus.Instruction[RA_L +: RA_W];
    assign rb     = bus.Instruction[0 +: RA_W];
    assign imm_f  = bus.Instruction[IMM_L +: W];
    assign cond   = 2'(ra);

    // Register file
    logic [W-1:0] rf_q [NREGS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (bus.writeBackEn) begin
            rf_q[bus.Dest_wb] <= bus.Result_WB;
        end
    end

    // Same-cycle bypass lets an instruction see the value being written back now.
    assign bus.Val_Ra = !rst ? '0 :
                        (bus.writeBackEn && bus.Dest_wb == ra) ? bus.Result_WB : rf_q[ra];
    assign bus.Val_Rb = !rst ? '0 :
                        (bus.writeBackEn && bus.Dest_wb == rb) ? bus.Result_WB : rf_q[rb];

    // Return-address stack
    logic         push, pop;
    logic [W-1:0] ras_top;

    ras_stack #(.W(W), .DEPTH(RAS_DEPTH)) u_ras (
        .clk   (clk),
        .rst_n (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.PC_in),
        .top   (ras_top),
        .count (bus.ras_count),
        .ovf   (bus.ras_ovf),
        .unf   (bus.ras_unf)
    );

    // Decode
    logic       wb, mr, mw, s, inp, outp, b, ill, s1en, s2en, use_imm;
    logic [3:0] cmd;
    logic [W-1:0] br_addr;

    always_comb begin
        wb = 1'b0; mr = 1'b0; mw = 1'b0; s = 1'b0; inp = 1'b0; outp = 1'b0;
        b = 1'b0; ill = 1'b0; s1en = 1'b0; s2en = 1'b0; use_imm = 1'b0;
        cmd = 4'h0;
        br_addr = '0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_SHR: begin
                wb = 1'b1; s = 1'b1; s1en = 1'b1; s2en = 1'b1; cmd = opcode;
            end
            OP_LDI:  begin wb = 1'b1; use_imm = 1'b1; end
            OP_LD:   begin wb = 1'b1; mr = 1'b1; s2en = 1'b1; end
            OP_ST:   begin mw = 1'b1; s1en = 1'b1; s2en = 1'b1; end
            OP_IN:   begin wb = 1'b1; inp = 1'b1; end
            OP_OUT:  begin outp = 1'b1; s1en = 1'b1; end
            OP_BR: begin
                br_addr = imm_f;
                case (cond)
                    COND_AL: b = 1'b1;
                    COND_Z:  b = bus.Z;
                    COND_N:  b = bus.N;
                    default: b = !bus.Z;
                endcase
            end
            OP_CALL: begin b = 1'b1; br_addr = imm_f; end
            // An empty stack yields ras_top = 0, giving the underflow target.
            OP_RET:  begin b = 1'b1; br_addr = ras_top; end
            OP_ILL:  ill = 1'b1;
            default: ;
        endcase

        push = (opcode == OP_CALL) && !bus.hazard;
        pop  = (opcode == OP_RET)  && !bus.hazard;

        // A squashed instruction keeps its source info for the hazard unit
        // but loses every effect on machine state.
        if (bus.hazard) begin
            wb = 1'b0; mr = 1'b0; mw = 1'b0; s = 1'b0; inp = 1'b0; outp = 1'b0;
            b = 1'b0; ill = 1'b0; cmd = 4'h0;
        end
    end

    assign bus.WB_EN    = wb;
    assign bus.MEM_R_EN = mr;
    assign bus.MEM_W_EN = mw;
    assign bus.S        = s;
    assign bus.inPort   = inp;
    assign bus.outPort  = outp;
    assign bus.EXE_CMD  = cmd;
    assign bus.imm      = use_imm;
    assign bus.Val_Imm  = imm_f;
    assign bus.Dest     = ra;
    assign bus.src1     = ra;
    assign bus.src2     = rb;
    assign bus.src1_en  = s1en;
    assign bus.src2_en  = s2en;
    assign bus.Br_addr  = br_addr;
    assign bus.B        = b;
    assign bus.illegal  = ill;

endmodule

// File: tb/tb_id_stage_ras.sv
// Bench for id_stage_ras (W=8, NREGS=4, RAS_DEPTH=4): directed literal checks
// followed by randomized traffic compared against a queue-based reference model.
module tb_id_stage_ras;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    id_stage_ras_if #(.W(8), .NREGS(4), .RAS_DEPTH(4)) bus ();

    id_stage_ras #(.W(8), .NREGS(4), .RAS_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state
    logic [7:0] m_rf [4];
    logic [7:0] m_ras [$];
    bit         m_ovf, m_unf;

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] ra,
                                       input logic [1:0] rb, input logic [7:0] im);
        return {im, op, ra, rb};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
        m_ras.delete();
        m_ovf = 0;
        m_unf = 0;
    endtask

    // Expected outputs from the instruction-set rules and the model state.
    task automatic compare_all();
        logic [3:0] op;
        logic [1:0] ra, rb;
        logic [7:0] im;
        logic e_wb, e_mr, e_mw, e_s, e_in, e_out, e_b, e_ill, e_s1, e_s2, e_imm;
        logic [3:0] e_cmd;
        logic [7:0] e_br, e_va, e_vb;
        op = bus.Instruction[7:4];
        ra = bus.Instruction[3:2];
        rb = bus.Instruction[1:0];
        im = bus.Instruction[15:8];
        {e_wb, e_mr, e_mw, e_s, e_in, e_out, e_b, e_ill, e_s1, e_s2, e_imm} = '0;
        e_cmd = 4'h0;
        e_br  = 8'h00;
        if (op >= 4'h1 && op <= 4'h6) begin
            e_wb = 1; e_s = 1; e_s1 = 1; e_s2 = 1; e_cmd = op;
        end else begin
            case (op)
                4'h7: begin e_wb = 1; e_imm = 1; end
                4'h8: begin e_wb = 1; e_mr = 1; e_s2 = 1; end
                4'h9: begin e_mw = 1; e_s1 = 1; e_s2 = 1; end
                4'hA: begin e_wb = 1; e_in = 1; end
                4'hB: begin e_out = 1; e_s1 = 1; end
                4'hC: begin
                    e_br = im;
                    e_b  = (ra == 0) ? 1'b1 : (ra == 1) ? bus.Z : (ra == 2) ? bus.N : !bus.Z;
                end
                4'hD: begin e_b = 1; e_br = im; end
                4'hE: begin e_b = 1; e_br = (m_ras.size() > 0) ? m_ras[$] : 8'h00; end
                4'hF: e_ill = 1;
                default: ;
            endcase
        end
        if (bus.hazard) begin
            {e_wb, e_mr, e_mw, e_s, e_in, e_out, e_b, e_ill} = '0;
            e_cmd = 4'h0;
        end
        e_va = !rst ? 8'h00 : (bus.writeBackEn && bus.Dest_wb == ra) ? bus.Result_WB : m_rf[ra];
        e_vb = !rst ? 8'h00 : (bus.writeBackEn && bus.Dest_wb == rb) ? bus.Result_WB : m_rf[rb];
        chk("WB_EN",    32'(bus.WB_EN),    32'(e_wb));
        chk("MEM_R_EN", 32'(bus.MEM_R_EN), 32'(e_mr));
        chk("MEM_W_EN", 32'(bus.MEM_W_EN), 32'(e_mw));
        chk("S",        32'(bus.S),        32'(e_s));
        chk("inPort",   32'(bus.inPort),   32'(e_in));
        chk("outPort",  32'(bus.outPort),  32'(e_out));
        chk("EXE_CMD",  32'(bus.EXE_CMD),  32'(e_cmd));
        chk("imm",      32'(bus.imm),      32'(e_imm));
        chk("Val_Imm",  32'(bus.Val_Imm),  32'(im));
        chk("Dest",     32'(bus.Dest),     32'(ra));
        chk("src1",     32'(bus.src1),     32'(ra));
        chk("src2",     32'(bus.src2),     32'(rb));
        chk("src1_en",  32'(bus.src1_en),  32'(e_s1));
        chk("src2_en",  32'(bus.src2_en),  32'(e_s2));
        chk("B",        32'(bus.B),        32'(e_b));
        chk("Br_addr",  32'(bus.Br_addr),  32'(e_br));
        chk("illegal",  32'(bus.illegal),  32'(e_ill));
        chk("Val_Ra",   32'(bus.Val_Ra),   32'(e_va));
        chk("Val_Rb",   32'(bus.Val_Rb),   32'(e_vb));
        chk("ras_count", 32'(bus.ras_count), 32'(m_ras.size()));
        chk("ras_ovf",  32'(bus.ras_ovf),  32'(m_ovf));
        chk("ras_unf",  32'(bus.ras_unf),  32'(m_unf));
    endtask

    task automatic model_update();
        logic [3:0] op;
        op = bus.Instruction[7:4];
        if (!rst) return;
        if (bus.writeBackEn) m_rf[bus.Dest_wb] = bus.Result_WB;
        if (!bus.hazard) begin
            if (op == 4'hD) begin
                if (m_ras.size() == 4) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1;
                end
                m_ras.push_back(bus.PC_in);
            end else if (op == 4'hE) begin
                if (m_ras.size() == 0) m_unf = 1;
                else void'(m_ras.pop_back());
            end
        end
    endtask

    // One clock: full check on the falling edge, then the model advances.
    task automatic cyc();
        @(negedge clk);
        compare_all();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [15:0] ins, input logic [7:0] pc, input logic hz);
        bus.Instruction = ins;
        bus.PC_in       = pc;
        bus.hazard      = hz;
    endtask

    initial begin
        rst = 1'b0;
        model_reset();
        bus.Instruction = mk(4'h1, 2'd1, 2'd2, 8'h00);
        bus.PC_in = 8'h00; bus.Result_WB = 8'hFF; bus.writeBackEn = 1'b1;
        bus.Dest_wb = 2'd1; bus.hazard = 1'b0; bus.Z = 1'b0; bus.N = 1'b0;
        #2;
        // Reset state, bypass suppressed while reset is held
        chk("rst_val_ra", 32'(bus.Val_Ra), 32'h0);
        chk("rst_count",  32'(bus.ras_count), 32'h0);
        chk("rst_ovf",    32'(bus.ras_ovf), 32'h0);
        chk("rst_unf",    32'(bus.ras_unf), 32'h0);
        bus.writeBackEn = 1'b0;
        #1 rst = 1'b1;

        // ADD R1,R2 with empty RF
        #1;
        chk("add_vra",  32'(bus.Val_Ra), 32'h0);
        chk("add_vrb",  32'(bus.Val_Rb), 32'h0);
        chk("add_wb",   32'(bus.WB_EN), 32'h1);
        chk("add_cmd",  32'(bus.EXE_CMD), 32'h1);
        chk("add_sen",  32'({bus.src1_en, bus.src2_en}), 32'h3);
        cyc();

        // Write-back bypass on R2, then registered value
        bus.writeBackEn = 1'b1; bus.Dest_wb = 2'd2; bus.Result_WB = 8'h5A;
        #1 chk("byp_vrb", 32'(bus.Val_Rb), 32'h5A);
        cyc();
        bus.writeBackEn = 1'b0; bus.Result_WB = 8'h00;
        #1 chk("rf_vrb", 32'(bus.Val_Rb), 32'h5A);
        cyc();

        // CALL then RET
        set_in(mk(4'hD, 2'd0, 2'd0, 8'h40), 8'h11, 1'b0);
        #1 chk("call_b", 32'(bus.B), 32'h1);
        chk("call_br", 32'(bus.Br_addr), 32'h40);
        cyc();
        chk("call_cnt", 32'(bus.ras_count), 32'h1);
        set_in(mk(4'hE, 2'd0, 2'd0, 8'h00), 8'h00, 1'b0);
        #1 chk("ret_b", 32'(bus.B), 32'h1);
        chk("ret_br", 32'(bus.Br_addr), 32'h11);
        cyc();
        chk("ret_cnt", 32'(bus.ras_count), 32'h0);

        // Overflow with five CALLs, then five RETs ending in underflow
        for (int i = 1; i <= 5; i++) begin
            set_in(mk(4'hD, 2'd0, 2'd0, 8'h20), 8'(i), 1'b0);
            cyc();
        end
        chk("ovf_cnt",  32'(bus.ras_count), 32'h4);
        chk("ovf_flag", 32'(bus.ras_ovf), 32'h1);
        for (int i = 0; i < 5; i++) begin
            logic [7:0] want;
            want = (i < 4) ? 8'(5 - i) : 8'h00;
            set_in(mk(4'hE, 2'd0, 2'd0, 8'h00), 8'h00, 1'b0);
            #1 chk("ret_seq_br", 32'(bus.Br_addr), 32'(want));
            chk("ret_seq_b", 32'(bus.B), 32'h1);
            cyc();
        end
        chk("unf_flag", 32'(bus.ras_unf), 32'h1);
        chk("unf_cnt",  32'(bus.ras_count), 32'h0);

        // Conditional branches
        set_in(mk(4'hC, 2'b01, 2'd0, 8'h77), 8'h00, 1'b0);
        bus.Z = 1'b0; #1 chk("brz_z0", 32'(bus.B), 32'h0);
        cyc();
        bus.Z = 1'b1; #1 chk("brz_z1", 32'(bus.B), 32'h1);
        chk("brz_addr", 32'(bus.Br_addr), 32'h77);
        cyc();
        set_in(mk(4'hC, 2'b11, 2'd0, 8'h77), 8'h00, 1'b0);
        bus.Z = 1'b0; #1 chk("brnz_z0", 32'(bus.B), 32'h1);
        cyc();
        bus.Z = 1'b1; #1 chk("brnz_z1", 32'(bus.B), 32'h0);
        cyc();

        // Squashed CALL, then the same CALL unsquashed
        set_in(mk(4'hD, 2'd0, 2'd0, 8'h30), 8'h99, 1'b1);
        #1 chk("hz_b",   32'(bus.B), 32'h0);
        chk("hz_ctl", 32'({bus.WB_EN, bus.MEM_R_EN, bus.MEM_W_EN, bus.S, bus.inPort,
                            bus.outPort, bus.EXE_CMD, bus.illegal}), 32'h0);
        cyc();
        chk("hz_cnt", 32'(bus.ras_count), 32'h0);
        bus.hazard = 1'b0;
        cyc();
        chk("hz_push", 32'(bus.ras_count), 32'h1);
        set_in(mk(4'h0, 2'd0, 2'd0, 8'h00), 8'h00, 1'b0);
        cyc();
        chk("hz_once", 32'(bus.ras_count), 32'h1);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            int r;
            logic [3:0] op;
            r  = int'($urandom_range(0, 21));
            op = (r >= 16) ? ((r % 2 == 0) ? 4'hD : 4'hE) : 4'(r);
            set_in(mk(op, 2'($urandom), 2'($urandom), 8'($urandom)), 8'($urandom),
                   ($urandom_range(0, 4) == 0));
            bus.writeBackEn = 1'($urandom);
            bus.Dest_wb     = 2'($urandom);
            bus.Result_WB   = 8'($urandom);
            bus.Z           = 1'($urandom);
            bus.N           = 1'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0;
                #1;
                model_reset();
                chk("async_cnt", 32'(bus.ras_count), 32'h0);
                chk("async_vra", 32'(bus.Val_Ra), 32'h0);
                chk("async_flags", 32'({bus.ras_ovf, bus.ras_unf}), 32'h0);
                rst = 1'b1;
                #1;
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
